// File: rtl/ssram_ctrl_pkg.sv
// Shared types and timing constants for the SSRAM macro controller.
// The read wait is the discharge count plus evaluate cycles plus margin.
package ssram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        RD_SETUP,
        RD_PULSE,
        RD_WAIT,
        RD_EVAL,
        RESP
    } state_e;

    localparam int RE_CYCLES     = 6;
    localparam int EN_STEP       = 2;
    localparam int RD_MARGIN_DEF = 8;
    localparam int EN_MAX_DEF    = 31;

    // Load value for the down-counter: it counts through zero, so it is one less than the wait length.
    function automatic logic [6:0] wait_load(input logic [5:0] en, input int margin);
        return 7'(int'(en) + RE_CYCLES + margin - 1);
    endfunction

endpackage

// File: rtl/ssram_ctrl_wait_cnt.sv
// Loadable 7-bit down-counter that times the RD_WAIT phase of a read.
// done_o is high while the count sits at zero.
module ssram_ctrl_wait_cnt
    import ssram_ctrl_pkg::*;
(
    input  logic       CLK_RBL,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [6:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [6:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 7'd0)) begin
            cnt_d = cnt_q - 7'd1;
        end
    end

    always_ff @(posedge CLK_RBL or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 7'd0);

endmodule

// File: rtl/ssram_ctrl.sv
// Controller for a read-bitline SSRAM macro: single-pulse writes, and reads
// with discharge-count retries that widen the discharge window on a failure flag.
module ssram_ctrl
    import ssram_ctrl_pkg::*;
#(
    parameter int RD_MARGIN = RD_MARGIN_DEF,
    parameter int EN_MAX    = EN_MAX_DEF
) (
    input  logic        CLK_RBL,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic [4:0]  cfg_en_i,
    input  logic [2:0]  cfg_max_retry_i,
    input  logic        cfg_boost_i,
    output logic        sram_clk_o,
    output logic        sram_cen_o,
    output logic        sram_wen_o,
    output logic        sram_mode_o,
    output logic        sram_boost_o,
    output logic [11:0] sram_en_o,
    output logic [7:0]  sram_brs_o,
    output logic [31:0] sram_d_o,
    input  logic [31:0] sram_q_i,
    input  logic        sram_flag_i
);

    state_e      state_q, state_d;
    logic [5:0]  en_q, en_d;
    logic [2:0]  retry_q, retry_d;
    logic        sram_clk_q, sram_clk_d;
    logic        sram_cen_q, sram_cen_d;
    logic        sram_wen_q, sram_wen_d;
    logic        sram_mode_q, sram_mode_d;
    logic        sram_boost_q, sram_boost_d;
    logic [11:0] sram_en_q, sram_en_d;
    logic [7:0]  sram_brs_q, sram_brs_d;
    logic [31:0] sram_d_q, sram_d_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [5:0]  en_step;
    logic [5:0]  en_sat;
    logic [6:0]  cnt_load_val;
    logic        cnt_load, cnt_dec, cnt_done;

    assign en_step      = en_q + 6'(EN_STEP);
    assign en_sat       = (en_step > 6'(EN_MAX)) ? 6'(EN_MAX) : en_step;
    assign cnt_load_val = wait_load(en_q, RD_MARGIN);

    ssram_ctrl_wait_cnt u_wait_cnt (
        .CLK_RBL    (CLK_RBL),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    always_comb begin
        // NOTE: every _d starts from its _q (or a fixed idle value) so no path through the case infers a latch.
        state_d      = state_q;
        en_d         = en_q;
        retry_d      = retry_q;
        sram_clk_d   = 1'b0;
        sram_cen_d   = sram_cen_q;
        sram_wen_d   = sram_wen_q;
        sram_mode_d  = sram_mode_q;
        sram_boost_d = cfg_boost_i;
        sram_en_d    = sram_en_q;
        sram_brs_d   = sram_brs_q;
        sram_d_d     = sram_d_q;
        rvalid_d     = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        gnt_o        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    gnt_o      = 1'b1;
                    en_d       = {1'b0, cfg_en_i};
                    retry_d    = cfg_max_retry_i;
                    sram_brs_d = addr_i;
                    sram_cen_d = 1'b0;
                    if (we_i) begin
                        sram_wen_d = 1'b0;
                        sram_d_d   = wdata_i;
                        state_d    = WR_SETUP;
                    end else begin
                        sram_wen_d = 1'b1;
                        sram_en_d  = {7'd0, cfg_en_i};
                        state_d    = RD_SETUP;
                    end
                end
            end
            WR_SETUP: begin
                sram_clk_d = 1'b1;
                state_d    = WR_PULSE;
            end
            WR_PULSE: begin
                rvalid_d = 1'b1;
                err_d    = 1'b0;
                state_d  = RESP;
            end
            RD_SETUP: begin
                sram_clk_d = 1'b1;
                state_d    = RD_PULSE;
            end
            RD_PULSE: begin
                cnt_load = 1'b1;
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_done) begin
                    state_d = RD_EVAL;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RD_EVAL: begin
                // A flagged read re-pulses with CEN still low and a longer discharge window.
                if (sram_flag_i && (retry_q != 3'd0)) begin
                    retry_d     = retry_q - 3'd1;
                    en_d        = en_sat;
                    sram_en_d   = {7'd0, en_sat[4:0]};
                    sram_mode_d = 1'b1;
                    sram_clk_d  = 1'b1;
                    state_d     = RD_PULSE;
                end else begin
                    rdata_d  = sram_q_i;
                    err_d    = sram_flag_i;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                sram_cen_d  = 1'b1;
                sram_wen_d  = 1'b1;
                sram_mode_d = 1'b0;
                err_d       = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop captures the pre-edge _d values together.
    always_ff @(posedge CLK_RBL or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            en_q         <= '0;
            retry_q      <= '0;
            sram_clk_q   <= 1'b0;
            sram_cen_q   <= 1'b1;
            sram_wen_q   <= 1'b1;
            sram_mode_q  <= 1'b0;
            sram_boost_q <= 1'b0;
            sram_en_q    <= '0;
            sram_brs_q   <= '0;
            sram_d_q     <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            retry_q      <= retry_d;
            sram_clk_q   <= sram_clk_d;
            sram_cen_q   <= sram_cen_d;
            sram_wen_q   <= sram_wen_d;
            sram_mode_q  <= sram_mode_d;
            sram_boost_q <= sram_boost_d;
            sram_en_q    <= sram_en_d;
            sram_brs_q   <= sram_brs_d;
            sram_d_q     <= sram_d_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign sram_clk_o   = sram_clk_q;
    assign sram_cen_o   = sram_cen_q;
    assign sram_wen_o   = sram_wen_q;
    assign sram_mode_o  = sram_mode_q;
    assign sram_boost_o = sram_boost_q;
    assign sram_en_o    = sram_en_q;
    assign sram_brs_o   = sram_brs_q;
    assign sram_d_o     = sram_d_q;
    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_ssram_ctrl.sv
// Bench for ssram_ctrl: a behavioural macro model plus scoreboards of expected
// responses and expected macro pulses, both filled when stimulus is issued.
module tb_ssram_ctrl;
    import ssram_ctrl_pkg::*;

    localparam int MARGIN = 8;
    localparam int ENMAX  = 31;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [7:0]  brs;
        logic [4:0]  en;
        logic        mode;
        logic [31:0] d;
    } pulse_t;

    logic        CLK_RBL = 1'b0;
    logic        rst_n   = 1'b0;
    logic        req_i, we_i, gnt_o, rvalid_o, err_o;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i, rdata_o;
    logic [4:0]  cfg_en_i;
    logic [2:0]  cfg_max_retry_i;
    logic        cfg_boost_i;
    logic        sram_clk_o, sram_cen_o, sram_wen_o, sram_mode_o, sram_boost_o;
    logic [11:0] sram_en_o;
    logic [7:0]  sram_brs_o;
    logic [31:0] sram_d_o, sram_q_i;
    logic        sram_flag_i;

    ssram_ctrl #(.RD_MARGIN(MARGIN), .EN_MAX(ENMAX)) dut (
        .CLK_RBL         (CLK_RBL),
        .rst_n           (rst_n),
        .req_i           (req_i),
        .we_i            (we_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .gnt_o           (gnt_o),
        .rvalid_o        (rvalid_o),
        .rdata_o         (rdata_o),
        .err_o           (err_o),
        .cfg_en_i        (cfg_en_i),
        .cfg_max_retry_i (cfg_max_retry_i),
        .cfg_boost_i     (cfg_boost_i),
        .sram_clk_o      (sram_clk_o),
        .sram_cen_o      (sram_cen_o),
        .sram_wen_o      (sram_wen_o),
        .sram_mode_o     (sram_mode_o),
        .sram_boost_o    (sram_boost_o),
        .sram_en_o       (sram_en_o),
        .sram_brs_o      (sram_brs_o),
        .sram_d_o        (sram_d_o),
        .sram_q_i        (sram_q_i),
        .sram_flag_i     (sram_flag_i)
    );

    always #5 CLK_RBL = ~CLK_RBL;

    int n_chk = 0;
    int n_err = 0;

    exp_t        sb_q[$];
    pulse_t      pulse_q[$];
    bit          flag_q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] mac_mem [256];
    logic [31:0] last_rdata = '0;

    int cyc = 0, last_gnt = 0, last_rv = 0, last_pulse = 0, gnt_gap = 0;
    int gnt_cnt = 0, resp_cnt = 0, viol = 0, cen_hi_busy = 0, gnt_busy = 0;
    bit busy = 0, clk_prev = 0, rv_prev = 0;
    exp_t   mon_e;
    pulse_t mon_p;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Macro model and output monitor, sampled on the falling edge.
    always @(negedge CLK_RBL) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            busy = 0; clk_prev = 0; rv_prev = 0;
        end else begin
            if (sram_clk_o && (sram_cen_o || clk_prev)) viol++;
            if (rvalid_o && rv_prev) viol++;
            clk_prev = sram_clk_o;
            rv_prev  = rvalid_o;
            if (busy && sram_cen_o) cen_hi_busy++;
            if (busy && gnt_o) gnt_busy++;
            if (gnt_o && !busy) begin
                busy = 1; last_gnt = cyc; gnt_cnt++; gnt_gap = cyc - last_rv;
            end
            if (sram_clk_o) begin
                last_pulse = cyc;
                if (pulse_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    mon_p = pulse_q.pop_front();
                    check("pulse_wen", sram_wen_o, !mon_p.wr);
                    check("pulse_brs", sram_brs_o, mon_p.brs);
                    if (mon_p.wr) begin
                        check("pulse_d", sram_d_o, mon_p.d);
                    end else begin
                        check("pulse_en", sram_en_o, {7'd0, mon_p.en});
                        check("pulse_mode", sram_mode_o, mon_p.mode);
                    end
                end
                if (!sram_wen_o) begin
                    mac_mem[sram_brs_o] = sram_d_o;
                end else begin
                    sram_q_i    = mac_mem[sram_brs_o];
                    sram_flag_i = (flag_q.size() > 0) ? flag_q.pop_front() : 1'b0;
                end
            end
            if (rvalid_o) begin
                last_rv = cyc;
                resp_cnt++;
                busy = 0;
                if (sb_q.size() == 0) begin
                    check("unexpected_rvalid", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rdata", rdata_o, mon_e.rdata);
                    check("err", err_o, mon_e.err);
                    check("latency", cyc - last_gnt, mon_e.lat);
                end
            end
        end
    end

    // Issues one transaction; expected response and macro pulses come from the bench's own model.
    task automatic txn(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [4:0] en, input logic [2:0] retry, input int nflags, input bit hold);
        exp_t   e;
        pulse_t p;
        int     cur_en, r, cycles;
        bit     fl;
        if (we) begin
            ref_mem[addr] = wdata;
            p.wr = 1'b1; p.brs = addr; p.en = '0; p.mode = 1'b0; p.d = wdata;
            pulse_q.push_back(p);
            e.rdata = last_rdata; e.err = 1'b0; e.lat = 3;
        end else begin
            cur_en = int'(en); r = int'(retry);
            e.lat = 2; e.err = 1'b0;
            for (int a = 0; a < 8; a++) begin
                p.wr = 1'b0; p.brs = addr; p.en = cur_en[4:0]; p.mode = (a > 0); p.d = '0;
                pulse_q.push_back(p);
                e.lat += cur_en + RE_CYCLES + MARGIN + 2;
                fl = (a < nflags);
                flag_q.push_back(fl);
                if (!fl) break;
                if (r == 0) begin
                    e.err = 1'b1;
                    break;
                end
                r--;
                cur_en = (cur_en + EN_STEP > ENMAX) ? ENMAX : cur_en + EN_STEP;
            end
            e.rdata = ref_mem[addr];
            last_rdata = e.rdata;
        end
        sb_q.push_back(e);

        @(posedge CLK_RBL); #1;
        we_i = we; addr_i = addr; wdata_i = wdata;
        cfg_en_i = en; cfg_max_retry_i = retry; req_i = 1'b1;
        cycles = 0;
        do begin
            @(negedge CLK_RBL); cycles++;
        end while (!gnt_o && cycles < 100);
        check("grant_seen", gnt_o, 1);
        if (!gnt_o) begin
            req_i = 1'b0;
            return;
        end
        @(posedge CLK_RBL); #1;
        if (!hold) req_i = 1'b0;
        cfg_en_i = ~en; cfg_max_retry_i = ~retry;
        cycles = 0;
        do begin
            @(negedge CLK_RBL); cycles++;
        end while (!rvalid_o && cycles < 400);
        check("response_seen", rvalid_o, 1);
        #1;
    endtask

    initial begin
        pulse_t pp;
        int     rc, g0, cycles;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = '0;
            mac_mem[i] = '0;
        end
        req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0;
        cfg_en_i = '0; cfg_max_retry_i = '0; cfg_boost_i = 0;
        sram_q_i = '0; sram_flag_i = 0;

        repeat (3) @(posedge CLK_RBL);
        #1;
        check("rst_cen", sram_cen_o, 1);
        check("rst_wen", sram_wen_o, 1);
        check("rst_clk", sram_clk_o, 0);
        check("rst_mode", sram_mode_o, 0);
        check("rst_boost", sram_boost_o, 0);
        check("rst_en", sram_en_o, 0);
        check("rst_brs", sram_brs_o, 0);
        check("rst_d", sram_d_o, 0);
        check("rst_gnt", gnt_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_err", err_o, 0);
        @(negedge CLK_RBL) rst_n = 1'b1;

        @(posedge CLK_RBL); #1;
        cfg_boost_i = 1'b1; #1;
        check("boost_not_comb", sram_boost_o, 0);
        @(posedge CLK_RBL); #1;
        check("boost_on", sram_boost_o, 1);
        cfg_boost_i = 1'b0;
        @(posedge CLK_RBL); #1;
        check("boost_off", sram_boost_o, 0);

        txn(1'b1, 8'h12, 32'hDEADBEEF, 5'd0, 3'd0, 0, 1'b0);
        txn(1'b0, 8'h12, 32'h0, 5'd4, 3'd0, 0, 1'b0);
        check("rd_wait_en4", last_rv - last_pulse - 2, 18);
        txn(1'b0, 8'h12, 32'h0, 5'd4, 3'd2, 1, 1'b0);
        txn(1'b1, 8'h34, 32'hCAFEF00D, 5'd9, 3'd5, 0, 1'b0);
        txn(1'b0, 8'h34, 32'h0, 5'd30, 3'd3, 4, 1'b0);
        txn(1'b0, 8'h34, 32'h0, 5'd0, 3'd1, 0, 1'b0);
        check("rd_wait_en0", last_rv - last_pulse - 2, 14);
        txn(1'b0, 8'h12, 32'h0, 5'd0, 3'd0, 1, 1'b0);

        // Abort a read in RD_WAIT with reset.
        pp.wr = 1'b0; pp.brs = 8'h12; pp.en = 5'd4; pp.mode = 1'b0; pp.d = '0;
        pulse_q.push_back(pp);
        @(posedge CLK_RBL); #1;
        we_i = 1'b0; addr_i = 8'h12; cfg_en_i = 5'd4; cfg_max_retry_i = 3'd0; req_i = 1'b1;
        cycles = 0;
        do begin
            @(negedge CLK_RBL); cycles++;
        end while (!gnt_o && cycles < 100);
        @(posedge CLK_RBL); #1;
        req_i = 1'b0;
        cycles = 0;
        do begin
            @(negedge CLK_RBL); cycles++;
        end while (!sram_clk_o && cycles < 100);
        check("abort_pulse_seen", sram_clk_o, 1);
        repeat (5) @(posedge CLK_RBL);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_cen", sram_cen_o, 1);
        check("abort_clk", sram_clk_o, 0);
        check("abort_rvalid", rvalid_o, 0);
        rc = resp_cnt;
        repeat (3) @(negedge CLK_RBL);
        rst_n = 1'b1;
        repeat (40) @(negedge CLK_RBL);
        #1;
        check("abort_no_rvalid", resp_cnt, rc);
        last_rdata = '0;

        txn(1'b1, 8'h56, 32'h0BADC0DE, 5'd1, 3'd1, 0, 1'b0);
        txn(1'b0, 8'h56, 32'h0, 5'd7, 3'd1, 1, 1'b0);

        // Request held across a whole read: the next grant lands the cycle after RESP.
        g0 = gnt_cnt;
        txn(1'b0, 8'h12, 32'h0, 5'd4, 3'd0, 0, 1'b1);
        txn(1'b0, 8'h56, 32'h0, 5'd2, 3'd0, 0, 1'b0);
        check("regrant_gap", gnt_gap, 1);
        check("grants_held_req", gnt_cnt - g0, 2);

        repeat (5) @(posedge CLK_RBL);
        #1;
        check("clk_protocol_viol", viol, 0);
        check("cen_high_while_busy", cen_hi_busy, 0);
        check("gnt_while_busy", gnt_busy, 0);
        check("sb_left", sb_q.size(), 0);
        check("pulses_left", pulse_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ssram_ctrl.md
SSRAM_CTRL -- requirements
Module: ssram_ctrl

Interface
REQ-001 SHALL have parameters: RD_MARGIN, default 8, extra wait cycles after discharge + evaluate; EN_MAX, default 31, saturation ceiling for discharge count.
REQ-002 SHALL have ports: CLK_RBL  in  1  controller and macro timing clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have bus ports: req_i in 1 request; we_i in 1 write; addr_i in 8 row address; wdata_i in 32 write data; gnt_o out 1 request accepted; rvalid_o out 1 response valid, one cycle; rdata_o out 32 read data; err_o out 1 read failed after all retries, qualified by rvalid_o.
REQ-004 SHALL have config ports: cfg_en_i in 5 initial discharge count; cfg_max_retry_i in 3 retries allowed; cfg_boost_i in 1 drive BOOST_EN.
REQ-005 SHALL have macro ports: sram_clk_o out 1; sram_cen_o out 1; sram_wen_o out 1; sram_mode_o out 1; sram_boost_o out 1; sram_en_o out 12; sram_brs_o out 8; sram_d_o out 32; sram_q_i in 32; sram_flag_i in 1.

Function
REQ-006 SHALL implement FSM states IDLE, WR_SETUP, WR_PULSE, RD_SETUP, RD_PULSE, RD_WAIT, RD_EVAL, RESP; all outputs registered.
REQ-007 IDLE: gnt_o SHALL be high combinationally only when req_i is high and state is IDLE; on grant, latch addr_i, wdata_i, we_i, cfg_en_i, cfg_max_retry_i.
REQ-008 Write: WR_SETUP drives cen=0, wen=0, brs, d for one cycle; WR_PULSE raises sram_clk_o for exactly one cycle; then RESP with rvalid_o=1, err_o=0, rdata_o unchanged.
REQ-009 Read: RD_SETUP drives cen=0, wen=1, brs, en[4:0]=current en, en[11:5]=0 for one cycle; RD_PULSE raises sram_clk_o for exactly one cycle; RD_WAIT counts en+6+RD_MARGIN cycles with CEN held low.
REQ-010 RD_EVAL SHALL sample sram_q_i and sram_flag_i; flag=0 -> RESP with rdata_o=q, err_o=0.
REQ-011 flag=1 and retries remaining>0 -> decrement retries, en=min(en+2, EN_MAX), sram_mode_o=1, return to RD_PULSE without raising CEN.
REQ-012 flag=1 and retries=0 -> RESP with rdata_o=q, err_o=1.
REQ-013 RESP: rvalid_o high exactly one cycle; then sram_cen_o=1, sram_mode_o=0, state IDLE; new grant no earlier than the cycle after RESP.
REQ-014 sram_clk_o SHALL be low for at least one cycle between pulses; sram_clk_o SHALL never be high while sram_cen_o=1.
REQ-015 Width rules: en arithmetic 6-bit internal, saturating at EN_MAX; wait counter 7-bit; cfg_en_i=0 is legal (wait = 6+RD_MARGIN).
REQ-016 Config changes during a transaction SHALL NOT affect it; sram_boost_o follows cfg_boost_i registered.
REQ-017 req_i held while busy SHALL be ignored (no gnt_o) and accepted in the next IDLE cycle.

Reset
REQ-018 On rst_n low: state IDLE; sram_cen_o=1, sram_wen_o=1, sram_clk_o=0, sram_mode_o=0, sram_boost_o=0, sram_en_o=0, sram_brs_o=0, sram_d_o=0, gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0; counters 0.
REQ-019 Reset mid-transaction SHALL abort it with no response; first request after release handled normally.

Structure
REQ-020 Package ssram_ctrl_pkg SHALL hold the state enum, RE_CYCLES=6, EN_STEP=2, and the default RD_MARGIN/EN_MAX constants.
REQ-021 One sub-module ssram_ctrl_wait_cnt (loadable down-counter with done flag) SHALL implement RD_WAIT timing; rest is flat.

Verification
REQ-022 Write addr 0x12 data 0xDEADBEEF -> one sram_clk_o pulse with cen=0, wen=0, brs=0x12; rvalid_o 3 cycles after gnt_o; err_o=0.
REQ-023 Read addr 0x12, cfg_en_i=4, macro flag=0 -> RD_WAIT exactly 18 cycles, rdata_o=0xDEADBEEF, err_o=0.
REQ-024 Read, cfg_en_i=4, max_retry=2, flag=1 first then 0 -> second pulse with en=6, mode=1, cen continuously low; err_o=0.
REQ-025 Read, cfg_en_i=30, max_retry=3, flag always 1 -> en sequence 30,31,31,31; four pulses; rvalid_o with err_o=1.
REQ-026 rst_n asserted during RD_WAIT -> cen=1, clk=0 immediately, no rvalid_o; following write completes normally.
REQ-027 req_i held through a read -> single gnt_o per transaction, second grant the cycle after RESP.
